// File: rtl/mpsk_mod.sv
// mpsk_mod: M-ary PSK modulator (BPSK / QPSK / 8PSK).
// A free-running phase accumulator addresses a shared 4096x12 sine ROM.
// The ROM is offset by the Gray-decoded symbol phase, and the output is
// framed by an IDLE/TX symbol FSM.
// Optional build macro: MPSK_DIFF_EN selects differential phase encoding.

// Sine ROM: 12-bit address, 12-bit two's-complement q (amplitude 2047),
// one registered cycle of latency. The quarter-wave table is built at
// elaboration, and the other three quadrants come from symmetry.
module mpsk_sine_rom (
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [11:0] q
);
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(2047 * sin(pi*k/2048)) using Q30 Taylor terms up to x^11
  function automatic int quarter_mag(input int k);
    longint x, x2, t, s;
    x  = (PI_Q30 * longint'(k)) >>> 11;
    x2 = (x * x) >>> 30;
    t  = x;
    s  = x;
    t  = ((t * x2) >>> 30) / 6;   s = s - t;
    t  = ((t * x2) >>> 30) / 20;  s = s + t;
    t  = ((t * x2) >>> 30) / 42;  s = s - t;
    t  = ((t * x2) >>> 30) / 72;  s = s + t;
    t  = ((t * x2) >>> 30) / 110; s = s - t;
    return int'((s * 2047 + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [10:0] quarter [1024];
  logic [9:0]  k_fwd;
  logic [9:0]  k_rev;
  logic [10:0] mag;

  for (genvar k = 0; k < 1024; k++) begin : g_quarter
    localparam logic [10:0] MAG = 11'(quarter_mag(k));
    assign quarter[k] = MAG;
  end

  // Fold the address into the first quadrant; the mirrored quadrants read
  // the table backwards, and their k=0 points hit the 2047 peak.
  always_comb begin
    k_fwd = addr[9:0];
    k_rev = 10'd0 - addr[9:0];
    if (!addr[10])
      mag = quarter[k_fwd];
    else if (k_fwd == '0)
      mag = 11'd2047;
    else
      mag = quarter[k_rev];
  end

  // Registered read; the lower half-cycle of the wave is negated
  always_ff @(posedge clk)
    q <= addr[11] ? 12'd0 - {1'b0, mag} : {1'b0, mag};
endmodule

module mpsk_mod #(
  parameter logic [63:0] FREQ_WORD    = 64'd153722867280913000,
  parameter int unsigned ACC_W        = 64,
  parameter int unsigned BITS_PER_SYM = 2,
  parameter int unsigned SPS          = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sym_valid,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  output logic                    sym_ready,
  output logic [11:0]             mod_data,
  output logic                    mod_valid,
  output logic                    busy
);
  localparam int unsigned      CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SPS - 1);
  localparam logic [ACC_W-1:0] STEP  = FREQ_WORD[ACC_W-1:0];

  typedef enum logic {IDLE, TX} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [ACC_W-1:0]        acc;
  logic [BITS_PER_SYM-1:0] phase_idx, idx_next, new_idx;
  logic                    ready;
  logic [11:0]             rom_addr;
  logic [11:0]             rom_q;

  function automatic logic [BITS_PER_SYM-1:0] gray2bin(input logic [BITS_PER_SYM-1:0] g);
    logic [BITS_PER_SYM-1:0] b;
    b = g;
    for (int unsigned i = 1; i < BITS_PER_SYM; i++)
      b[BITS_PER_SYM-1-i] = b[BITS_PER_SYM-i] ^ g[BITS_PER_SYM-1-i];
    return b;
  endfunction

`ifdef MPSK_DIFF_EN
  assign new_idx = phase_idx + gray2bin(sym_data);
`else
  assign new_idx = gray2bin(sym_data);
`endif

  assign busy      = (state == TX);
  assign sym_ready = rst & ready;

  // ROM is addressed with the index that will be in force after this
  // edge. An accepted symbol's first sample therefore uses the current
  // accumulator value, and the one-cycle ROM latency lines up with the
  // registered output stage.
  assign rom_addr = acc[ACC_W-1 -: 12] + (12'(idx_next) << (12 - BITS_PER_SYM));

  // Symbol FSM: next state, counter, phase index and ready handshake
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = phase_idx;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (sym_valid) begin
          state_next = TX;
          cnt_next   = '0;
          idx_next   = new_idx;
        end
      end
      TX: begin
        if (cnt == LAST) begin
          ready = 1'b1;
          if (sym_valid) begin
            cnt_next = '0;
            idx_next = new_idx;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator free-runs in every state; FSM state, counter and phase register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phase_idx <= '0;
      acc       <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      phase_idx <= idx_next;
      acc       <= acc + STEP;
    end
  end

  mpsk_sine_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .q    (rom_q)
  );

  // Output stage: valid trails busy by one cycle; data is zero when invalid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mod_valid <= 1'b0;
      mod_data  <= '0;
    end else begin
      mod_valid <= busy;
      mod_data  <= busy ? rom_q : '0;
    end
  end
endmodule

// File: tb/tb_mpsk_mod.sv
// Directed testbench for mpsk_mod: BPSK, QPSK and 8PSK instances,
// each sharing one clock and each with its own reset and stimulus.
module tb_mpsk_mod;
  localparam logic [63:0] FW = 64'h0010_0000_0000_0000; // 2^52: +1 per cycle in acc top bits

  logic clk = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  logic        rst1, v1, r1, mv1, b1;
  logic [0:0]  d1;
  logic [11:0] md1;
  logic        rst2, v2, r2, mv2, b2;
  logic [1:0]  d2;
  logic [11:0] md2;
  logic        rst3, v3, r3, mv3, b3;
  logic [2:0]  d3;
  logic [11:0] md3;

  always #5 clk = ~clk;

  mpsk_mod #(.FREQ_WORD(FW), .ACC_W(64), .BITS_PER_SYM(1), .SPS(4)) dut_bpsk (
    .clk(clk), .rst(rst1), .sym_valid(v1), .sym_data(d1), .sym_ready(r1),
    .mod_data(md1), .mod_valid(mv1), .busy(b1));

  mpsk_mod #(.FREQ_WORD(FW), .ACC_W(64), .BITS_PER_SYM(2), .SPS(4)) dut_qpsk (
    .clk(clk), .rst(rst2), .sym_valid(v2), .sym_data(d2), .sym_ready(r2),
    .mod_data(md2), .mod_valid(mv2), .busy(b2));

  mpsk_mod #(.FREQ_WORD(FW), .ACC_W(64), .BITS_PER_SYM(3), .SPS(4)) dut_8psk (
    .clk(clk), .rst(rst3), .sym_valid(v3), .sym_data(d3), .sym_ready(r3),
    .mod_data(md3), .mod_valid(mv3), .busy(b3));

  function automatic int sine_ref(input int a);
    real r;
    r = 2047.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 4096.0);
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d1 = '0; d2 = '0; d3 = '0;
    repeat (3) step();
    #2;
    checks++;
    if ({r1, b1, mv1, md1} !== 15'd0) begin
      failures++; $display("FAIL reset_bpsk_outputs got=%h want=0", {r1, b1, mv1, md1});
    end
    checks++;
    if ({r2, b2, mv2, md2} !== 15'd0) begin
      failures++; $display("FAIL reset_qpsk_outputs got=%h want=0", {r2, b2, mv2, md2});
    end
    checks++;
    if ({r3, b3, mv3, md3} !== 15'd0) begin
      failures++; $display("FAIL reset_8psk_outputs got=%h want=0", {r3, b3, mv3, md3});
    end
    step();
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    #2;
    checks++;
    if ({r1, r2, r3} !== 3'b111) begin
      failures++; $display("FAIL release_ready got=%b want=111", {r1, r2, r3});
    end
    checks++;
    if ({b1, b2, b3, mv1, mv2, mv3} !== 6'd0) begin
      failures++; $display("FAIL release_idle got=%b want=000000", {b1, b2, b3, mv1, mv2, mv3});
    end
  endtask

  task automatic test_bpsk_single();
    logic [2:0] exp_ctrl [7] = '{3'b010, 3'b100, 3'b101, 3'b101, 3'b111, 3'b011, 3'b010};
    int         exp_a    [7] = '{0, 0, 2048, 2049, 2050, 2051, 0};
    int got;
    int want;
    rst1 = 1'b0; step(); rst1 = 1'b1;
    v1 = 1'b1; d1 = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (j == 1) v1 = 1'b0;
      #2;
      checks++;
      if ({b1, r1, mv1} !== exp_ctrl[j]) begin
        failures++; $display("FAIL bpsk_ctrl cycle=%0d got=%b want=%b", j, {b1, r1, mv1}, exp_ctrl[j]);
      end
      if (j < 4) begin
        checks++;
        if (dut_bpsk.rom_addr !== 12'(2048 + j)) begin
          failures++; $display("FAIL bpsk_addr cycle=%0d got=%0d want=%0d", j, dut_bpsk.rom_addr, 2048 + j);
        end
      end
      checks++;
      if (exp_ctrl[j][0]) begin
        got  = int'($signed(md1));
        want = sine_ref(exp_a[j]);
        if (got - want > 1 || want - got > 1) begin
          failures++; $display("FAIL bpsk_data cycle=%0d got=%0d want=%0d", j, got, want);
        end
      end else if (md1 !== 12'd0) begin
        failures++; $display("FAIL bpsk_data_zero cycle=%0d got=%0d want=0", j, md1);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] syms [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         off  [4] = '{0, 1024, 2048, 3072};
    logic [2:0] want_ctrl;
    int got;
    int want;
    rst2 = 1'b0; step(); rst2 = 1'b1;
    v2 = 1'b1; d2 = syms[0];
    for (int j = 0; j < 19; j++) begin
      if (j < 16 && j % 4 == 0) d2 = syms[j / 4];
      if (j == 16) v2 = 1'b0;
      #2;
      want_ctrl = {(j >= 1 && j <= 16), (j % 4 == 0 || j >= 17), (j >= 2 && j <= 17)};
      checks++;
      if ({b2, r2, mv2} !== want_ctrl) begin
        failures++; $display("FAIL qpsk_ctrl cycle=%0d got=%b want=%b", j, {b2, r2, mv2}, want_ctrl);
      end
      if (j < 16) begin
        checks++;
        if (dut_qpsk.rom_addr !== 12'(j + off[j / 4])) begin
          failures++; $display("FAIL qpsk_addr cycle=%0d got=%0d want=%0d", j, dut_qpsk.rom_addr, j + off[j / 4]);
        end
      end
      checks++;
      if (want_ctrl[0]) begin
        got  = int'($signed(md2));
        want = sine_ref((j - 2) + off[(j - 2) / 4]);
        if (got - want > 1 || want - got > 1) begin
          failures++; $display("FAIL qpsk_data cycle=%0d got=%0d want=%0d", j, got, want);
        end
      end else if (md2 !== 12'd0) begin
        failures++; $display("FAIL qpsk_data_zero cycle=%0d got=%0d want=0", j, md2);
      end
      step();
    end
    step();
    v2 = 1'b1; d2 = 2'b00;
    #2;
    checks++;
    if (dut_qpsk.rom_addr !== 12'd20) begin
      failures++; $display("FAIL acc_runs_in_idle got=%0d want=20", dut_qpsk.rom_addr);
    end
    step();
    v2 = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid_symbol();
    int got;
    rst2 = 1'b0; step(); rst2 = 1'b1;
    v2 = 1'b1; d2 = 2'b11;
    step();
    v2 = 1'b0;
    step(); step();
    #2;
    checks++;
    if ({b2, mv2} !== 2'b11) begin
      failures++; $display("FAIL mid_symbol_active got=%b want=11", {b2, mv2});
    end
    rst2 = 1'b0;
    #1;
    checks++;
    if ({r2, b2, mv2, md2} !== 15'd0) begin
      failures++; $display("FAIL async_reset_outputs got=%h want=0", {r2, b2, mv2, md2});
    end
    step(); step();
    rst2 = 1'b1; v2 = 1'b1; d2 = 2'b01;
    #2;
    checks++;
    if (r2 !== 1'b1) begin
      failures++; $display("FAIL ready_after_abort got=%b want=1", r2);
    end
    checks++;
    if (dut_qpsk.rom_addr !== 12'd1024) begin
      failures++; $display("FAIL addr_after_abort got=%0d want=1024", dut_qpsk.rom_addr);
    end
    step();
    v2 = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      #2;
      checks++;
      if ({b2, r2} !== {1'b1, 1'(j == 4)}) begin
        failures++; $display("FAIL restart_count cycle=%0d got=%b want=%b", j, {b2, r2}, {1'b1, 1'(j == 4)});
      end
      if (j == 2) begin
        got = int'($signed(md2));
        checks++;
        if (mv2 !== 1'b1 || got - sine_ref(1024) > 1 || sine_ref(1024) - got > 1) begin
          failures++; $display("FAIL restart_data got=%0d valid=%b want=%0d", got, mv2, sine_ref(1024));
        end
      end
      step();
    end
    repeat (4) step();
  endtask

  task automatic test_diff_encoding();
`ifdef MPSK_DIFF_EN
    int off [4] = '{1024, 2048, 3072, 0};
`else
    int off [4] = '{1024, 1024, 1024, 1024};
`endif
    rst2 = 1'b0; step(); rst2 = 1'b1;
    v2 = 1'b1; d2 = 2'b01;
    for (int j = 0; j <= 12; j++) begin
      #2;
      if (j % 4 == 0) begin
        checks++;
        if (dut_qpsk.rom_addr !== 12'(j + off[j / 4])) begin
          failures++; $display("FAIL phase_index sym=%0d got=%0d want=%0d", j / 4, dut_qpsk.rom_addr, j + off[j / 4]);
        end
      end
      step();
    end
    v2 = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_8psk_wrap();
    int got;
    int want;
    rst3 = 1'b0; step(); rst3 = 1'b1;
    v3 = 1'b0; d3 = '0;
    repeat (4095) step();
    #2;
    checks++;
    if ({r3, b3} !== 2'b10 || dut_8psk.rom_addr !== 12'd4095) begin
      failures++; $display("FAIL idle_acc_4095 got=%0d rdy_busy=%b want=4095/10", dut_8psk.rom_addr, {r3, b3});
    end
    v3 = 1'b1; d3 = 3'b100;
    #1;
    checks++;
    if (dut_8psk.rom_addr !== 12'd3583) begin
      failures++; $display("FAIL addr_wrap_8psk got=%0d want=3583", dut_8psk.rom_addr);
    end
    step();
    d3 = 3'b011;
    #2;
    checks++;
    if (r3 !== 1'b0 || dut_8psk.rom_addr !== 12'd3584) begin
      failures++; $display("FAIL ignore_data_not_ready got=%0d ready=%b want=3584/0", dut_8psk.rom_addr, r3);
    end
    step();
    v3 = 1'b0;
    #2;
    got  = int'($signed(md3));
    want = sine_ref(3583);
    checks++;
    if (mv3 !== 1'b1 || got - want > 1 || want - got > 1) begin
      failures++; $display("FAIL data_wrap_8psk got=%0d valid=%b want=%0d", got, mv3, want);
    end
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_bpsk_single();
    test_back_to_back();
    test_reset_mid_symbol();
    test_diff_encoding();
    test_8psk_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
